data_bus_os_scheduler: RTL
==========================

# data_bus_os_scheduler

Controller that sequences the lane data bus: round-robin arbitrates ordered-set (OS) transmit requests from N requesters, drives `d_sel` into the data bus, waits for `os_sent`, and returns a per-requester completion pulse. When no OS is pending and transport traffic is enabled, it switches the data bus into transport-data mode. It sits between the link control FSMs and the data bus.

## Interface
Parameters:
- `N_REQ`, 3: number of OS requesters (2..8).
- `TIMEOUT_CYC`, 1024: max cycles to wait for `os_sent` (only with `OS_TIMEOUT_EN`).

Ports:
- `fsm_clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester OS request level; held until that requester's `done` pulse.
- `req_os`  in  4*N_REQ  OS code per requester; slice i = bits [4i+3:4i]; stable while `req[i]` is high.
- `data_mode_req`  in  1  transport layer wants data mode.
- `os_sent`  in  1  data bus reports the current OS has been fully transmitted.
- `d_sel`  out  4  OS select to the data bus.
- `data_os`  out  1  1 = transport-data mode, 0 = OS mode.
- `done`  out  N_REQ  one-cycle pulse, one-hot, completing requester i.
- `bad_req`  out  1  one-cycle pulse alongside `done` when the completed request had an illegal code.
- `busy`  out  1  high in any state except IDLE.
- `timeout_err`  out  1  one-cycle pulse on OS timeout (0 without the macro).

## Operation
- `d_sel` codes: 4'h0 = D_SEL_IDLE, 4'hF = D_SEL_DATA; 4'h1..4'hE = legal OS codes.
- States: IDLE, WAIT_SENT, DATA.
- IDLE: `d_sel`=IDLE, `data_os`=0. If any `req` high: round-robin pick, starting search at `rr_ptr`; winner w.
  - `req_os[w]` legal -> register `d_sel`=`req_os[w]`, go WAIT_SENT.
  - `req_os[w]` illegal (0 or F) -> pulse `done[w]` and `bad_req` next cycle, stay IDLE, `rr_ptr`=w+1.
  - Else if `data_mode_req` -> go DATA.
- WAIT_SENT: hold `d_sel`. On `os_sent`=1: pulse `done[w]`, `d_sel`=IDLE, `rr_ptr`=(w+1) mod N_REQ, go IDLE.
- DATA: `d_sel`=D_SEL_DATA, `data_os`=1. If `data_mode_req`=0 or any `req` high -> go IDLE (`d_sel`=IDLE, `data_os`=0).
- OS requests have priority over data mode; requests never preempt an OS in WAIT_SENT.
- `req[w]` dropping during WAIT_SENT is illegal; the block still completes normally.
- `os_sent` outside WAIT_SENT is ignored.

## Timing
- Reset values: `d_sel`=4'h0, `data_os`=0, `done`=0, `bad_req`=0, `busy`=0, `timeout_err`=0, `rr_ptr`=0, state IDLE.
- All outputs registered. `req` high at edge k -> `d_sel` valid after edge k.
- `os_sent` high at edge k -> `done[w]` high for exactly the cycle after edge k; `d_sel`=IDLE in the same cycle.
- Earliest next grant: `d_sel` updates one cycle after `done` (IDLE always takes one cycle).
- DATA entry/exit: one cycle each.
- `rst` asserted mid-operation: all outputs clear immediately; no `done` for the aborted request.

## Configuration
- `DATA_BUS_OS_TIMEOUT_EN` defined: WAIT_SENT counter (width clog2(TIMEOUT_CYC)) cleared on entry; when it reaches TIMEOUT_CYC-1 without `os_sent`, pulse `timeout_err` and `done[w]`, `d_sel`=IDLE, advance `rr_ptr`, go IDLE. `os_sent` on the same cycle wins (normal completion, no error).
- Not defined: no counter; WAIT_SENT waits indefinitely; `timeout_err` tied 0.

## Structure
- Package `data_bus_ctrl_pkg`: state enum, D_SEL_IDLE, D_SEL_DATA, OS code constants.
- Sub-module `rr_arbiter`: parameterized N_REQ round-robin picker (req vector + pointer -> one-hot grant + index), combinational.

## Test plan
- Single request: `req[0]`=1, code 4'h3; `os_sent` 5 cycles later -> `d_sel`=3 for 6 cycles, `done[0]` pulses once, `d_sel` returns to 0.
- Fairness: `req`=3'b111 held, `os_sent` after every grant -> grant order 0,1,2,0.
- Illegal code: `req[1]`=1, code 4'hF -> `done[1]` and `bad_req` pulse, `d_sel` never leaves 0.
- Data mode: `data_mode_req`=1 -> `d_sel`=F, `data_os`=1; raise `req[2]` (code 4'h5) -> IDLE for one cycle, then `d_sel`=5; after `done`, back to DATA.
- Timeout (macro on, TIMEOUT_CYC=16): no `os_sent` -> `timeout_err` and `done[w]` after 16 WAIT_SENT cycles; macro off -> waits indefinitely.
- Reset during WAIT_SENT -> all outputs 0, no `done`; the held request is granted anew after `rst` is released.

Source files
------------

// File: rtl/data_bus_ctrl_pkg.sv
// Shared types and constants for the lane data-bus OS scheduler.
package data_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SENT = 2'd1,
    ST_DATA      = 2'd2
  } sched_state_t;

  localparam logic [3:0] D_SEL_IDLE  = 4'h0;
  localparam logic [3:0] D_SEL_DATA  = 4'hF;
  localparam logic [3:0] OS_CODE_MIN = 4'h1;
  localparam logic [3:0] OS_CODE_MAX = 4'hE;

  function automatic logic os_code_legal(input logic [3:0] code);
    return (code >= OS_CODE_MIN) && (code <= OS_CODE_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr wins.
module rr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_j = IW'((32'(i_ptr) + i) % N_REQ);
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_bus_os_scheduler.sv
// Data-bus sequencer: arbitrates OS transmit requests, else enters transport-data mode.
// Optional OS-sent timeout enabled by defining DATA_BUS_OS_TIMEOUT_EN.
module data_bus_os_scheduler
  import data_bus_ctrl_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               fsm_clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_os,
  input  logic               data_mode_req,
  input  logic               os_sent,
  output logic [3:0]         d_sel,
  output logic               data_os,
  output logic [N_REQ-1:0]   done,
  output logic               bad_req,
  output logic               busy,
  output logic               timeout_err
);
  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("data_bus_os_scheduler: N_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  sched_state_t     r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_next_ptr;
  logic [N_REQ-1:0] r_cur_grant;
  logic [3:0]       r_d_sel;
  logic             r_data_os;
  logic [N_REQ-1:0] r_done;
  logic             r_bad;
  logic             r_busy;
  logic             r_tmo;

  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_next_ptr;
  logic             w_any;
  logic [3:0]       w_win_os;
  logic             w_tmo_hit;

  // A requester sees done one cycle late; mask it so it is not re-granted.
  assign w_req_eff = req & ~r_done;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (w_req_eff),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_win_os = D_SEL_IDLE;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_win_os = req_os[4*i +: 4];
    end
  end

  assign w_next_ptr = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

`ifdef DATA_BUS_OS_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] r_cnt;

  assign w_tmo_hit = (r_cnt == TMO_LAST) && !os_sent;
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_next_ptr  <= '0;
      r_cur_grant <= '0;
      r_d_sel     <= D_SEL_IDLE;
      r_data_os   <= 1'b0;
      r_done      <= '0;
      r_bad       <= 1'b0;
      r_busy      <= 1'b0;
      r_tmo       <= 1'b0;
`ifdef DATA_BUS_OS_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_done <= '0;
      r_bad  <= 1'b0;
      r_tmo  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            if (os_code_legal(w_win_os)) begin
              r_d_sel     <= w_win_os;
              r_cur_grant <= w_grant;
              r_next_ptr  <= w_next_ptr;
              r_busy      <= 1'b1;
              r_state     <= ST_WAIT_SENT;
`ifdef DATA_BUS_OS_TIMEOUT_EN
              r_cnt       <= '0;
`endif
            end else begin
              r_done   <= w_grant;
              r_bad    <= 1'b1;
              r_rr_ptr <= w_next_ptr;
            end
          end else if (data_mode_req) begin
            r_d_sel   <= D_SEL_DATA;
            r_data_os <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_DATA;
          end
        end
        ST_WAIT_SENT: begin
          if (os_sent || w_tmo_hit) begin
            r_done   <= r_cur_grant;
            r_tmo    <= w_tmo_hit;
            r_d_sel  <= D_SEL_IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= r_next_ptr;
            r_state  <= ST_IDLE;
          end
`ifdef DATA_BUS_OS_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_DATA: begin
          if (!data_mode_req || (|req)) begin
            r_d_sel   <= D_SEL_IDLE;
            r_data_os <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_d_sel   <= D_SEL_IDLE;
          r_data_os <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_sel       = r_d_sel;
  assign data_os     = r_data_os;
  assign done        = r_done;
  assign bad_req     = r_bad;
  assign busy        = r_busy;
  assign timeout_err = r_tmo;

endmodule
